clk_div_ctrl: RTL

//  Owns the ratio input of clock_divider. Accepts divide-ratio requests on a valid/ready handshake,

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clk_fall_det.sv | 24 ++
 rtl/clk_div_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state encoding and default configuration for the
// clk_div_ctrl ratio controller.
// Optional feature macro: CLKDIV_TIMEOUT_EN (adds the default timeout length).
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    SETTLE    = 2'd2
  } state_t;

  localparam int DEF_DIV_W          = 16;
  localparam int DEF_DEFAULT_DIV    = 4;
  localparam int DEF_MIN_DIV        = 2;
  localparam int DEF_MAX_DIV        = 1024;
  localparam int DEF_SETTLE_PERIODS = 2;
`ifdef CLKDIV_TIMEOUT_EN
  localparam int DEF_TIMEOUT_CYC    = 64;
`endif

endpackage

// File: rtl/clk_fall_det.sv
// clk_fall_det: detects falling edges of the divided clock, sampled in the
// clk_in domain. The history bit resets to 0 so a low clk_out_mon right after
// reset never reads as a fall.
module clk_fall_det (
  input  logic clk_in,
  input  logic rstn,
  input  logic clk_out_mon,
  output logic fall
);

  logic prevMon_q;

  // Remember last cycle's clk_out_mon level for edge comparison.
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      prevMon_q <= 1'b0;
    end else begin
      prevMon_q <= clk_out_mon;
    end
  end

  assign fall = prevMon_q & ~clk_out_mon;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: accepts divide-ratio requests, range-checks them, swaps the
// ratio only on a clk_out falling edge and then waits a number of clk_out
// falls before acknowledging with done. Rejected requests pulse err.
// Optional feature macro: CLKDIV_TIMEOUT_EN (abort with err when clk_out stops).
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W          = DEF_DIV_W,
  parameter int DEFAULT_DIV    = DEF_DEFAULT_DIV,
  parameter int MIN_DIV        = DEF_MIN_DIV,
  parameter int MAX_DIV        = DEF_MAX_DIV,
  parameter int SETTLE_PERIODS = DEF_SETTLE_PERIODS
`ifdef CLKDIV_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC    = DEF_TIMEOUT_CYC
`endif
) (
  input  logic             clk_in,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DIV_W-1:0] req_div,
  input  logic             clk_out_mon,
  output logic [DIV_W-1:0] int_div,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Settle counter is sized to hold SETTLE_PERIODS; keep at least one bit
  // so a zero-length settle still elaborates.
  localparam int CNT_W = (SETTLE_PERIODS > 0) ? $clog2(SETTLE_PERIODS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((SETTLE_PERIODS > 0) ? SETTLE_PERIODS - 1 : 0);
  localparam logic [DIV_W-1:0] MIN_V = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] MAX_V = DIV_W'(MAX_DIV);
  localparam logic [DIV_W-1:0] DEF_V = DIV_W'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] intDiv_q, intDiv_d;
  logic [DIV_W-1:0] pendDiv_q, pendDiv_d;
  logic [CNT_W-1:0] fallCnt_q, fallCnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             fall;
  logic             tmoHit;

  clk_fall_det u_fall_det (
    .clk_in      (clk_in),
    .rstn        (rstn),
    .clk_out_mon (clk_out_mon),
    .fall        (fall)
  );

`ifdef CLKDIV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;

  assign tmoHit = (state_q != IDLE) && (tmoCnt_q == TMO_LAST);

  // Cycle counter restarts on every state change and counts while busy.
  always_comb begin
    tmoCnt_d = '0;
    if (state_q != IDLE && state_d == state_q) begin
      tmoCnt_d = tmoCnt_q + TMO_W'(1);
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      tmoCnt_q <= '0;
    end else begin
      tmoCnt_q <= tmoCnt_d;
    end
  end
`else
  assign tmoHit = 1'b0;
`endif

  // Next-state and datapath decisions; a fall always beats a timeout.
  always_comb begin
    state_d   = state_q;
    intDiv_d  = intDiv_q;
    pendDiv_d = pendDiv_q;
    fallCnt_d = fallCnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_div < MIN_V || req_div > MAX_V) begin
            err_d = 1'b1;
          end else if (req_div == intDiv_q) begin
            done_d = 1'b1;
          end else begin
            pendDiv_d = req_div;
            state_d   = WAIT_EDGE;
          end
        end
      end
      WAIT_EDGE: begin
        if (fall) begin
          intDiv_d  = pendDiv_q;
          fallCnt_d = '0;
          if (SETTLE_PERIODS == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SETTLE;
          end
        end else if (tmoHit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      SETTLE: begin
        if (fall) begin
          if (fallCnt_q == CNT_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            fallCnt_d = fallCnt_q + CNT_W'(1);
          end
        end else if (tmoHit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state registers; reset drops any in-flight request.
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      state_q   <= IDLE;
      intDiv_q  <= DEF_V;
      pendDiv_q <= '0;
      fallCnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      intDiv_q  <= intDiv_d;
      pendDiv_q <= pendDiv_d;
      fallCnt_q <= fallCnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign int_div   = intDiv_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
